// File: rtl/matrix_3x3_gen.sv
// matrix_3x3_gen
// Builds a registered 3x3 pixel neighbourhood from a raster-order stream.
// The incoming stream is forwarded combinationally to an external two-line
// buffer whose taps (previous line, line before that) come back in on
// taps1x/taps0x in the same cycle as the matching dat_in pixel.
// Optional feature macro: MATRIX_OUT_REG_EN adds one output pipeline register
// on the window, matrix_valid and frame_done (latency 1 -> 2 cycles).
module matrix_3x3_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 720
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [DATA_WIDTH-1:0] dat_in,
  input  logic                  dat_in_valid,
  output logic [DATA_WIDTH-1:0] lb_dat,
  output logic                  lb_dat_valid,
  input  logic [DATA_WIDTH-1:0] taps1x,
  input  logic [DATA_WIDTH-1:0] taps0x,
  output logic [DATA_WIDTH-1:0] p11,
  output logic [DATA_WIDTH-1:0] p12,
  output logic [DATA_WIDTH-1:0] p13,
  output logic [DATA_WIDTH-1:0] p21,
  output logic [DATA_WIDTH-1:0] p22,
  output logic [DATA_WIDTH-1:0] p23,
  output logic [DATA_WIDTH-1:0] p31,
  output logic [DATA_WIDTH-1:0] p32,
  output logic [DATA_WIDTH-1:0] p33,
  output logic                  matrix_valid,
  output logic                  frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  // Handshake: a pixel is accepted on every rising edge where rst_n=1 and
  // dat_in_valid=1; there is no backpressure, the block always accepts.

  // The line buffer sees exactly the stream we see, with zero latency.
  assign lb_dat       = dat_in;
  assign lb_dat_valid = dat_in_valid;

  // Position counters (pre-increment position of the pixel being accepted).
  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;

  // Window rows: index 2 = column c-2 (p*1), 1 = c-1 (p*2), 0 = c (p*3).
  logic [2:0][DATA_WIDTH-1:0] top_q, top_d;
  logic [2:0][DATA_WIDTH-1:0] mid_q, mid_d;
  logic [2:0][DATA_WIDTH-1:0] bot_q, bot_d;

  logic valid_q, valid_d;
  logic done_q, done_d;

  // Counter next-state, window-valid and end-of-frame decode.
  always_comb begin
    col_eff = frame_start ? '0 : col_q;
    row_eff = frame_start ? '0 : row_q;
    col_d   = col_eff;
    row_d   = row_eff;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (dat_in_valid) begin
      // Windows whose left columns belong to the previous line stay unflagged.
      valid_d = (row_eff >= ROW_MIN) && (col_eff >= COL_MIN);
      done_d  = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
      if (col_eff == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
      end
    end
  end

  // Window shift rows advance only on accepted pixels.
  always_comb begin
    top_d = top_q;
    mid_d = mid_q;
    bot_d = bot_q;
    if (dat_in_valid) begin
      top_d = {top_q[1:0], taps0x};
      mid_d = {mid_q[1:0], taps1x};
      bot_d = {bot_q[1:0], dat_in};
    end
  end

  // Core state register; reset clears everything except the external buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      top_q   <= '0;
      mid_q   <= '0;
      bot_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      top_q   <= top_d;
      mid_q   <= mid_d;
      bot_q   <= bot_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  logic [2:0][DATA_WIDTH-1:0] top_out, mid_out, bot_out;
  logic                       valid_out, done_out;

`ifdef MATRIX_OUT_REG_EN
  logic [2:0][DATA_WIDTH-1:0] top_o_q, mid_o_q, bot_o_q;
  logic                       valid_o_q, done_o_q;

  // Extra output stage: unconditional copy of the core window each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      top_o_q   <= '0;
      mid_o_q   <= '0;
      bot_o_q   <= '0;
      valid_o_q <= 1'b0;
      done_o_q  <= 1'b0;
    end else begin
      top_o_q   <= top_q;
      mid_o_q   <= mid_q;
      bot_o_q   <= bot_q;
      valid_o_q <= valid_q;
      done_o_q  <= done_q;
    end
  end

  assign top_out   = top_o_q;
  assign mid_out   = mid_o_q;
  assign bot_out   = bot_o_q;
  assign valid_out = valid_o_q;
  assign done_out  = done_o_q;
`else
  assign top_out   = top_q;
  assign mid_out   = mid_q;
  assign bot_out   = bot_q;
  assign valid_out = valid_q;
  assign done_out  = done_q;
`endif

  assign p11 = top_out[2];
  assign p12 = top_out[1];
  assign p13 = top_out[0];
  assign p21 = mid_out[2];
  assign p22 = mid_out[1];
  assign p23 = mid_out[0];
  assign p31 = bot_out[2];
  assign p32 = bot_out[1];
  assign p33 = bot_out[0];

  assign matrix_valid = valid_out;
  assign frame_done   = done_out;

endmodule

// File: doc/matrix_3x3_gen.md
# matrix_3x3_gen

Builds a 3x3 pixel neighbourhood from a raster-order pixel stream, for median filtering and edge detection. It sits directly downstream of the two-line shift-register buffer (`shift_register_2taps`):
- it forwards the incoming stream into that buffer;
- it takes the buffer's two tap outputs (previous line, line before that) back in;
- it assembles a registered 3x3 window with a qualifying valid strobe and an end-of-frame pulse.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width; must match the line buffer.
- IMG_WIDTH, 1280, pixels per line; must equal the line-buffer depth per tap.
- IMG_HEIGHT, 720, lines per frame.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- frame_start  in  1  single-cycle pulse; clears position counters.
- dat_in  in  DATA_WIDTH  input pixel, raster order.
- dat_in_valid  in  1  dat_in qualifier; one pixel accepted per cycle when high.
- lb_dat  out  DATA_WIDTH  to line buffer dat_in; combinational copy of dat_in.
- lb_dat_valid  out  1  to line buffer dat_in_valid; combinational copy of dat_in_valid.
- taps1x  in  DATA_WIDTH  line buffer output, row r-1, same column as dat_in, same cycle.
- taps0x  in  DATA_WIDTH  line buffer output, row r-2, same column as dat_in, same cycle.
- p11,p12,p13  out  DATA_WIDTH each  window top row (oldest line), left to right.
- p21,p22,p23  out  DATA_WIDTH each  window middle row; p22 is the centre.
- p31,p32,p33  out  DATA_WIDTH each  window bottom row (current line).
- matrix_valid  out  1  window holds a complete in-image 3x3 neighbourhood.
- frame_done  out  1  single-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Accepted pixel: a cycle with rst_n=1 and dat_in_valid=1.

Counters:
- col_cnt: 0..IMG_WIDTH-1. row_cnt: 0..IMG_HEIGHT-1. Widths are $clog2 of the respective bound.
- On each accepted pixel: col_cnt increments. When col_cnt=IMG_WIDTH-1 it wraps to 0 and row_cnt increments.
- When row_cnt=IMG_HEIGHT-1 and col_cnt=IMG_WIDTH-1, both wrap to 0. The next frame is then implicitly aligned without frame_start.

Window:
- Three 3-stage shift rows, shifting only on accepted pixels:
  - top row shifts in taps0x into p13, then p13 to p12, p12 to p11;
  - middle row shifts in taps1x into p23;
  - bottom row shifts in dat_in into p33.
- Column c-2 is p*1, column c-1 is p*2, column c is p*3.

Valid and frame-end:
- matrix_valid is registered. It is set to (row_cnt>=2 && col_cnt>=2), evaluated on the pre-increment counts at each accepted pixel. It is cleared on any cycle without an accepted pixel.
- Centre pixel p22 therefore corresponds to image position (row_cnt-1, col_cnt-1).
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). Windows straddling a line wrap are never flagged valid.
- frame_done is registered. It is set for one cycle when the accepted pixel has row_cnt=IMG_HEIGHT-1 and col_cnt=IMG_WIDTH-1.

frame_start:
- Synchronously clears col_cnt and row_cnt.
- If dat_in_valid is high in the same cycle, that pixel is pixel (0,0) of the new frame: counters become col=1, row=0, and matrix_valid is 0.
- Window registers are not cleared. Stale contents are masked by the row_cnt/col_cnt gating.

Reset and stalls:
- Reset (rst_n=0) has priority over everything. Counters, all p registers, matrix_valid and frame_done go to 0.
- Line-buffer contents are not reset; row gating masks them.
- Reset mid-frame: the next accepted pixel is treated as (0,0).
- dat_in_valid gaps of any length: all state holds; matrix_valid and frame_done are 0 during gaps.

## Timing
- lb_dat / lb_dat_valid: zero latency (combinational).
- Window and matrix_valid: 1 cycle after the accepting edge (2 with the macro below).
- Throughput: one window per clock when dat_in_valid is held high.
- First valid window of a frame: after the accepted pixel (2,2), i.e. the 2*IMG_WIDTH+3rd accepted pixel.
- frame_done: same cycle as the last window's matrix_valid.

## Configuration
- MATRIX_OUT_REG_EN defined:
  - adds one output pipeline register on p11..p33, matrix_valid and frame_done;
  - latency becomes 2 cycles; the register resets to 0.
- MATRIX_OUT_REG_EN undefined: latency is 1 cycle, as described above.

## Test plan
Benches use a behavioural line-buffer model of depth IMG_WIDTH, with IMG_WIDTH=8 and IMG_HEIGHT=6.
- Continuous frame, pixel value = row*16+col:
  - exactly 24 matrix_valid cycles;
  - first window p11..p33 = 0x00,01,02,10,11,12,20,21,22;
  - frame_done coincides with the window centred on 0x46.
- Random dat_in_valid gaps (30% idle): window sequence identical to the continuous case; matrix_valid and frame_done never high on idle-following cycles without a new pixel.
- Line wrap: pixels (3,0) and (3,1) accepted produce matrix_valid=0; pixel (3,2) produces valid with p22=0x21.
- frame_start mid-frame (row 3), held together with a valid pixel: that pixel counts as (0,0); no matrix_valid until new-frame pixel (2,2); 24 windows in the following frame.
- rst_n low for 1 cycle mid-frame:
  - all outputs are 0 in the next cycle;
  - the frame restarted afterwards yields 24 correct windows;
  - with MATRIX_OUT_REG_EN, each window appears one cycle later than without it.
